// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus definitions for the system bus arbiter
//
// Purpose: bus widths, read/write and active-low enable encodings, and the
// fixed master indices used by the arbiter and its bus interface.
// Ports: none (package).
package bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int MASTER_CPU_IF  = 0;
  localparam int MASTER_CPU_MEM = 1;

  typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
  typedef logic [BUS_DATA_W-1:0] bus_data_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - shared system bus: master request side and slave side
//
// Purpose: groups the per-master request fields and the muxed slave-side
// request into one bundle.
// Signals:
//   m_req_, m_as_, m_rw        per-master request, strobe, read/write
//   m_addr, m_wr_data          per-master address / write data, master i at [i*W +: W]
//   m_grnt_                    per-master grant, active-low, one-hot-low
//   s_addr, s_as_, s_rw, s_wr_data  granted master's request toward the slaves
// Modports:
//   master  the arbiter, which masters the slave-side bus on behalf of the owner
//   slave   the requesting masters / environment, which follow the arbiter's grants
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  import bus_arbiter_pkg::*;

  logic [NUM_MASTERS-1:0]            m_req_;
  logic [NUM_MASTERS-1:0]            m_grnt_;
  logic [NUM_MASTERS*BUS_ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0]            m_as_;
  logic [NUM_MASTERS-1:0]            m_rw;
  logic [NUM_MASTERS*BUS_DATA_W-1:0] m_wr_data;

  bus_addr_t s_addr;
  logic      s_as_;
  logic      s_rw;
  bus_data_t s_wr_data;

  modport master (
    input  m_req_, m_addr, m_as_, m_rw, m_wr_data,
    output m_grnt_, s_addr, s_as_, s_rw, s_wr_data
  );

  modport slave (
    output m_req_, m_addr, m_as_, m_rw, m_wr_data,
    input  m_grnt_, s_addr, s_as_, s_rw, s_wr_data
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin next-owner search
//
// Purpose: finds the first requesting master after the current owner,
// searching owner+1, owner+2, ... with wrap-around.
// Ports:
//   req_i          per-master request, active-low
//   owner_i        current owner index
//   exclude_self_i when set, the current owner is never returned
//   next_o         index of the first requester found (owner_i if none)
//   found_o        a requester was found
module bus_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  localparam int OWNER_W     = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OWNER_W-1:0]     owner_i,
  input  logic                   exclude_self_i,
  output logic [OWNER_W-1:0]     next_o,
  output logic                   found_o
);

  logic [OWNER_W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the last hit
  // written is the nearest one. Offset NUM_MASTERS wraps to the owner itself
  // because NUM_MASTERS is a power of two.
  always_comb begin
    next_o  = owner_i;
    found_o = 1'b0;
    idx     = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = owner_i + OWNER_W'(i);
      if (req_i[idx] == ENABLE_ && !(exclude_self_i && i == NUM_MASTERS)) begin
        next_o  = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter and slave-side request mux
//
// Purpose: owns the shared system bus for one master at a time, hands it
// over in round-robin order when the owner drops its request, and drives the
// owner's request onto the slave side. Slave read data / ready are broadcast
// elsewhere and do not pass through here.
// Configuration: define BUS_TIMEOUT_EN to revoke an owner that holds the bus
// for TIMEOUT_CYCLES consecutive cycles (timeout_irq pulses on revoke).
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset; parks the bus on master 0
//   bus          bus_arbiter_if.master: master requests in, grants and slave side out
//   owner        index of the current bus owner
//   timeout_irq  one-cycle pulse on forced revoke (0 without BUS_TIMEOUT_EN)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int OWNER_W        = $clog2(NUM_MASTERS)
) (
  input  logic               clk,
  input  logic               reset,
  bus_arbiter_if.master      bus,
  output logic [OWNER_W-1:0] owner,
  output logic               timeout_irq
);

  if (NUM_MASTERS < 2 || (NUM_MASTERS & (NUM_MASTERS - 1)) != 0) begin : g_bad_num_masters
    $error("bus_arbiter: NUM_MASTERS must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               owner_req;
  logic [OWNER_W-1:0] pick_next;
  logic               pick_found;

  assign owner_req = (bus.m_req_[owner_q] == ENABLE_);

  // While the owner still requests, the only search is a timeout revoke,
  // which must skip the owner; otherwise the owner is idle and cannot match.
  bus_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_rr_pick (
    .req_i          (bus.m_req_),
    .owner_i        (owner_q),
    .exclude_self_i (owner_req),
    .next_o         (pick_next),
    .found_o        (pick_found)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= OWNER_W'(MASTER_CPU_IF);
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    owner_d = owner_q;
    if (!owner_req && pick_found) begin
      owner_d = pick_next;
    end
`ifdef BUS_TIMEOUT_EN
    cnt_d = cnt_q;
    irq_d = 1'b0;
    if (!owner_req) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Revoke even when nobody else is waiting: the irq still reports it.
      cnt_d = '0;
      irq_d = 1'b1;
      if (pick_found) begin
        owner_d = pick_next;
      end
    end else begin
      // Never passes CNT_LAST, so the counter cannot wrap.
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // Outputs: grants decoded from owner, slave side muxed from owner
  always_comb begin
    owner = owner_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.m_grnt_[i] = (owner_q == OWNER_W'(i)) ? ENABLE_ : DISABLE_;
    end
    bus.s_addr    = bus.m_addr[int'(owner_q)*BUS_ADDR_W +: BUS_ADDR_W];
    bus.s_wr_data = bus.m_wr_data[int'(owner_q)*BUS_DATA_W +: BUS_DATA_W];
    bus.s_rw      = bus.m_rw[owner_q];
    // An idle parked owner never strobes; reset blocks the strobe at once,
    // without waiting for a clock edge.
    bus.s_as_     = !reset | bus.m_as_[owner_q] | bus.m_req_[owner_q];
`ifdef BUS_TIMEOUT_EN
    timeout_irq   = irq_q;
`else
    timeout_irq   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector testbench for bus_arbiter
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] owner;
  logic       timeout_irq;

  bus_arbiter_if #(.NUM_MASTERS(NM)) bus();

  bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .owner       (owner),
    .timeout_irq (timeout_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req_;
    logic [3:0] as_;
    logic [1:0] exp_owner;
    logic       exp_s_as_;
  } vec_t;

  vec_t      vecs[16];
  bus_addr_t addr_v[NM];
  bus_data_t data_v[NM];
  logic [3:0] rw_v;
  int        n_vec = 0;
  int        n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_masters();
    for (int i = 0; i < NM; i++) begin
      bus.m_addr[i*BUS_ADDR_W +: BUS_ADDR_W]    = addr_v[i];
      bus.m_wr_data[i*BUS_DATA_W +: BUS_DATA_W] = data_v[i];
    end
    bus.m_rw = rw_v;
  endtask

  task automatic check_bus(input string tag, input logic [1:0] o, input logic s_as_exp);
    logic [3:0] g;
    g = ~(4'b0001 << o);
    check({tag, ".owner"}, 32'(owner), 32'(o));
    check({tag, ".grnt"}, 32'(bus.m_grnt_), 32'(g));
    check({tag, ".s_addr"}, 32'(bus.s_addr), 32'(addr_v[o]));
    check({tag, ".s_wr_data"}, bus.s_wr_data, data_v[o]);
    check({tag, ".s_rw"}, 32'(bus.s_rw), 32'(rw_v[o]));
    check({tag, ".s_as"}, 32'(bus.s_as_), 32'(s_as_exp));
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      addr_v[i] = 30'h0AB0000 | 30'(i);
      data_v[i] = 32'hC0DE0000 + 32'(i);
    end
    rw_v = 4'b0101;

    //           req_     as_      owner  s_as_
    vecs[0]  = '{4'b1111, 4'b1111, 2'd0, 1'b1};
    vecs[1]  = '{4'b1011, 4'b1011, 2'd2, 1'b0};
    vecs[2]  = '{4'b1011, 4'b1111, 2'd2, 1'b1};
    vecs[3]  = '{4'b1111, 4'b1011, 2'd2, 1'b1};
    vecs[4]  = '{4'b1101, 4'b1101, 2'd1, 1'b0};
    vecs[5]  = '{4'b0110, 4'b0110, 2'd3, 1'b0};
    vecs[6]  = '{4'b1110, 4'b1110, 2'd0, 1'b0};
    vecs[7]  = '{4'b1110, 4'b1111, 2'd0, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[9]  = '{4'b1001, 4'b1001, 2'd1, 1'b0};
    vecs[10] = '{4'b1011, 4'b1011, 2'd2, 1'b0};
    vecs[11] = '{4'b0111, 4'b0111, 2'd3, 1'b0};
    vecs[12] = '{4'b1111, 4'b0111, 2'd3, 1'b1};
    vecs[13] = '{4'b1110, 4'b1110, 2'd0, 1'b0};
    vecs[14] = '{4'b0101, 4'b0101, 2'd1, 1'b0};
    vecs[15] = '{4'b0110, 4'b0110, 2'd3, 1'b0};

    // Reset state, with master 0 requesting and strobing so the reset gate on s_as_ matters
    load_masters();
    bus.m_req_ = 4'b0000;
    bus.m_as_  = 4'b0000;
    reset = 1'b0;
    #1;
    check_bus("reset", 2'd0, 1'b1);
    check("reset.irq", 32'(timeout_irq), 32'd0);

    @(negedge clk);
    bus.m_req_ = 4'b1111;
    bus.m_as_  = 4'b1111;
    reset = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      bus.m_req_ = vecs[v].req_;
      bus.m_as_  = vecs[v].as_;
      @(posedge clk);
      #1;
      check_bus($sformatf("vec%0d", v), vecs[v].exp_owner, vecs[v].exp_s_as_);
    end

    // Asynchronous reset mid-transfer: owner 3 active, master 0 requesting with strobe low
    @(negedge clk);
    bus.m_req_ = 4'b0110;
    bus.m_as_  = 4'b0110;
    #2;
    reset = 1'b0;
    #1;
    check_bus("midreset.async", 2'd0, 1'b1);
    @(posedge clk);
    #1;
    check_bus("midreset.edge", 2'd0, 1'b1);

    // Owner 0 holds, master 1 waits
    @(negedge clk);
    bus.m_req_ = 4'b1100;
    bus.m_as_  = 4'b1111;
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
`ifdef BUS_TIMEOUT_EN
      check($sformatf("timeout.owner.e%0d", e), 32'(owner), (e >= 8) ? 32'd1 : 32'd0);
      check($sformatf("timeout.irq.e%0d", e), 32'(timeout_irq), (e == 8) ? 32'd1 : 32'd0);
`else
      check($sformatf("notimeout.owner.e%0d", e), 32'(owner), 32'd0);
      check($sformatf("notimeout.irq.e%0d", e), 32'(timeout_irq), 32'd0);
`endif
    end

`ifndef BUS_TIMEOUT_EN
    // Owner 1 holds for 50 cycles against all others; slave side tracks master 1
    @(negedge clk);
    bus.m_req_ = 4'b1101;
    @(posedge clk);
    #1;
    check("hold.take", 32'(owner), 32'd1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.m_req_ = 4'b0000;
      addr_v[1] = 30'($urandom);
      data_v[1] = $urandom;
      load_masters();
      @(posedge clk);
      #1;
      check_bus($sformatf("hold.c%0d", c), 2'd1, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
